xlr8_tone_gen: RTL and testbench

- Multi-channel square-wave tone generator XB on the AVR data-memory register interface.
- Each of NUM_CH channels has a programmable 16-bit half-period, an 8-bit auto-stop duration and an enable bit.
- Each channel drives one speaker pin.
- A shared prescaler sets the tone time base; a second divider sets the duration time base.

---
 rtl/xlr8_tone_gen.sv | 177 +++++++++++++++++
 tb/tb_xlr8_tone_gen.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xlr8_tone_gen.sv
// Multi-channel square-wave tone generator on the AVR data-memory register bus.
// Shared prescaler drives per-channel half-period counters; a second divider times auto-stop durations.
module xlr8_tone_gen #(
  parameter logic [7:0] CTRL_ADDR  = 8'h00,
  parameter logic [7:0] ENA_ADDR   = 8'h00,
  parameter logic [7:0] CHSEL_ADDR = 8'h00,
  parameter logic [7:0] PERL_ADDR  = 8'h00,
  parameter logic [7:0] PERH_ADDR  = 8'h00,
  parameter logic [7:0] DUR_ADDR   = 8'h00,
  parameter int         NUM_CH     = 2,
  parameter int         PRESCALE   = 16,
  parameter int         DUR_DIV    = 1000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clken,
  input  logic [7:0]        dbus_in,
  output logic [7:0]        dbus_out,
  output logic              io_out_en,
  input  logic [7:0]        ramadr,
  input  logic              ramre,
  input  logic              ramwe,
  input  logic              dm_sel,
  output logic [NUM_CH-1:0] spk_out,
  output logic              done_pulse
);
  localparam int PW = $clog2(PRESCALE);
  localparam int DW = (DUR_DIV > 1) ? $clog2(DUR_DIV) : 1;

  logic sel_ctrl, sel_ena, sel_chsel, sel_perl, sel_perh, sel_dur;
  logic wr_ctrl, wr_ena, wr_chsel, wr_perl, wr_perh, wr_dur;

  assign sel_ctrl  = dm_sel && (ramadr == CTRL_ADDR);
  assign sel_ena   = dm_sel && (ramadr == ENA_ADDR);
  assign sel_chsel = dm_sel && (ramadr == CHSEL_ADDR);
  assign sel_perl  = dm_sel && (ramadr == PERL_ADDR);
  assign sel_perh  = dm_sel && (ramadr == PERH_ADDR);
  assign sel_dur   = dm_sel && (ramadr == DUR_ADDR);

  assign wr_ctrl  = clken && ramwe && sel_ctrl;
  assign wr_ena   = clken && ramwe && sel_ena;
  assign wr_chsel = clken && ramwe && sel_chsel;
  assign wr_perl  = clken && ramwe && sel_perl;
  assign wr_perh  = clken && ramwe && sel_perh;
  assign wr_dur   = clken && ramwe && sel_dur;

  assign io_out_en = ramre && (sel_ctrl || sel_ena || sel_chsel || sel_perl || sel_perh || sel_dur);

  logic              gen_reg;
  logic [NUM_CH-1:0] ena_reg;
  logic [2:0]        chsel_reg;
  logic [7:0]        stage_reg;
  logic [PW-1:0]     presc_reg;
  logic [DW-1:0]     ddiv_reg;
  logic              done_reg;

  logic              clr, tick, dtick;
  logic [NUM_CH-1:0] ch_hit, stop;
  logic [15:0]       period_w  [NUM_CH];
  logic [7:0]        dur_rem_w [NUM_CH];

  assign clr   = wr_ctrl && dbus_in[1];
  assign tick  = gen_reg && (presc_reg == PW'(PRESCALE - 1));
  assign dtick = tick && (ddiv_reg == DW'(DUR_DIV - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gen_reg   <= 1'b0;
      ena_reg   <= '0;
      chsel_reg <= 3'd0;
      stage_reg <= 8'd0;
      presc_reg <= '0;
      ddiv_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      if (wr_ctrl)  gen_reg   <= dbus_in[0];
      if (wr_chsel) chsel_reg <= dbus_in[2:0];
      if (wr_perh)  stage_reg <= dbus_in;

      // A CPU write to ENA overrides a coincident hardware auto-stop clear.
      if (clr)         ena_reg <= '0;
      else if (wr_ena) ena_reg <= dbus_in[NUM_CH-1:0];
      else             ena_reg <= ena_reg & ~stop;

      if (clr || !gen_reg)               presc_reg <= '0;
      else if (presc_reg == PW'(PRESCALE - 1)) presc_reg <= '0;
      else                               presc_reg <= presc_reg + 1'b1;

      if (clr || !gen_reg) ddiv_reg <= '0;
      else if (dtick)      ddiv_reg <= '0;
      else if (tick)       ddiv_reg <= ddiv_reg + 1'b1;

      done_reg <= |stop;
    end
  end

  assign done_pulse = done_reg;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [15:0] period_reg, cnt_reg;
    logic [7:0]  dur_set_reg, dur_rem_reg;
    logic        spk_reg;
    logic        active, commit, dec;

    assign ch_hit[gi] = (chsel_reg == 3'(gi));
    assign commit     = wr_perl && ch_hit[gi];
    assign active     = gen_reg && ena_reg[gi] && (period_reg != 16'd0);
    assign dec        = dtick && active && (dur_set_reg != 8'd0) && (dur_rem_reg != 8'd0);
    assign stop[gi]   = dec && (dur_rem_reg == 8'd1) && !wr_ena && !clr;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        period_reg  <= 16'd0;
        cnt_reg     <= 16'd0;
        dur_set_reg <= 8'd0;
        dur_rem_reg <= 8'd0;
        spk_reg     <= 1'b0;
      end else begin
        if (commit) period_reg <= {stage_reg, dbus_in};
        if (wr_dur && ch_hit[gi]) dur_set_reg <= dbus_in;

        if (clr)                          dur_rem_reg <= 8'd0;
        else if (wr_dur && ch_hit[gi])    dur_rem_reg <= dbus_in;
        else if (wr_ena && dbus_in[gi])   dur_rem_reg <= dur_set_reg;
        else if (dec)                     dur_rem_reg <= dur_rem_reg - 8'd1;

        // Idle channels park at cnt=0/low so the next activation toggles on its first tick.
        if (clr || commit || !active || stop[gi]) begin
          cnt_reg <= 16'd0;
          spk_reg <= 1'b0;
        end else if (tick) begin
          if (cnt_reg == 16'd0) begin
            cnt_reg <= period_reg - 16'd1;
            spk_reg <= ~spk_reg;
          end else begin
            cnt_reg <= cnt_reg - 16'd1;
          end
        end
      end
    end

    assign spk_out[gi]   = spk_reg;
    assign period_w[gi]  = period_reg;
    assign dur_rem_w[gi] = dur_rem_reg;
  end

  logic [15:0] sel_period;
  logic [7:0]  sel_dur_rem;
  logic [7:0]  ena_rd;

  always_comb begin
    sel_period  = 16'd0;
    sel_dur_rem = 8'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_hit[i]) begin
        sel_period  = sel_period | period_w[i];
        sel_dur_rem = sel_dur_rem | dur_rem_w[i];
      end
    end
  end

  always_comb begin
    ena_rd = 8'd0;
    ena_rd[NUM_CH-1:0] = ena_reg;
  end

  always_comb begin
    dbus_out = 8'd0;
    if (sel_ctrl)  dbus_out = dbus_out | {7'd0, gen_reg};
    if (sel_ena)   dbus_out = dbus_out | ena_rd;
    if (sel_chsel) dbus_out = dbus_out | {5'd0, chsel_reg};
    if (sel_perl)  dbus_out = dbus_out | sel_period[7:0];
    if (sel_perh)  dbus_out = dbus_out | sel_period[15:8];
    if (sel_dur)   dbus_out = dbus_out | sel_dur_rem;
  end

endmodule

// File: tb/tb_xlr8_tone_gen.sv
// Scoreboard bench for xlr8_tone_gen: reads push expectations, a negedge monitor pops and compares.
// Waveform timing (toggles, auto-stop, clear, async reset) is checked against hand-computed cycle positions.
module tb_xlr8_tone_gen;
  localparam logic [7:0] A_CTRL  = 8'h20;
  localparam logic [7:0] A_ENA   = 8'h21;
  localparam logic [7:0] A_CHSEL = 8'h22;
  localparam logic [7:0] A_PERL  = 8'h23;
  localparam logic [7:0] A_PERH  = 8'h24;
  localparam logic [7:0] A_DUR   = 8'h25;

  logic       clk = 1'b0;
  logic       rstn, clken, ramre, ramwe, dm_sel;
  logic [7:0] dbus_in, dbus_out, ramadr;
  logic       io_out_en, done_pulse;
  logic [1:0] spk_out;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;
  exp_t sb[$];
  exp_t cur;

  xlr8_tone_gen #(
    .CTRL_ADDR(A_CTRL), .ENA_ADDR(A_ENA), .CHSEL_ADDR(A_CHSEL),
    .PERL_ADDR(A_PERL), .PERH_ADDR(A_PERH), .DUR_ADDR(A_DUR),
    .NUM_CH(2), .PRESCALE(4), .DUR_DIV(2)
  ) dut (
    .clk(clk), .rstn(rstn), .clken(clken), .dbus_in(dbus_in), .dbus_out(dbus_out),
    .io_out_en(io_out_en), .ramadr(ramadr), .ramre(ramre), .ramwe(ramwe),
    .dm_sel(dm_sel), .spk_out(spk_out), .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT drives a read, compare against the oldest expectation.
  always @(negedge clk) begin
    if (io_out_en) begin
      if (sb.size() == 0) begin
        check("unexpected_read", 1, 0);
      end else begin
        cur = sb.pop_front();
        $display("read %-12s dbus_out=0x%02h expected=0x%02h", cur.name, dbus_out, cur.exp);
        check(cur.name, int'(dbus_out), int'(cur.exp));
      end
    end
    if (done_pulse) done_cnt++;
  end

  // Bus tasks are entered one time unit after a posedge and return at the same phase.
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    $display("write addr=0x%02h data=0x%02h", a, d);
    dm_sel = 1'b1; ramadr = a; dbus_in = d; ramwe = 1'b1; clken = 1'b1;
    @(posedge clk); #1;
    dm_sel = 1'b0; ramwe = 1'b0; clken = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
    dm_sel = 1'b1; ramadr = a; ramre = 1'b1;
    @(posedge clk); #1;
    dm_sel = 1'b0; ramre = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   tog[$];
    int   hi0;
    logic prev;

    rstn = 1'b0; clken = 1'b0; ramre = 1'b0; ramwe = 1'b0; dm_sel = 1'b0;
    dbus_in = 8'd0; ramadr = 8'd0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Reset state
    check("rst_spk", int'(spk_out), 0);
    rd(A_CTRL, 8'h00, "rst_ctrl");
    rd(A_ENA, 8'h00, "rst_ena");
    rd(A_CHSEL, 8'h00, "rst_chsel");
    rd(A_PERL, 8'h00, "rst_perl");
    rd(A_PERH, 8'h00, "rst_perh");
    rd(A_DUR, 8'h00, "rst_dur");

    // Register masking: CLR reads back 0, ENA bits above NUM_CH read 0
    wr(A_CTRL, 8'h03);
    rd(A_CTRL, 8'h01, "ctrl_mask");
    wr(A_ENA, 8'hFF);
    rd(A_ENA, 8'h03, "ena_mask");
    wr(A_CTRL, 8'h02);
    rd(A_ENA, 8'h00, "ena_clr");
    rd(A_CTRL, 8'h00, "ctrl_off");

    // Frequency: period 3, prescale 4 -> first toggle 4 clk after GEN, then every 12 clk
    wr(A_CHSEL, 8'h01);
    wr(A_PERH, 8'h00);
    wr(A_PERL, 8'h03);
    wr(A_ENA, 8'h02);
    wr(A_CTRL, 8'h01);
    prev = spk_out[1];
    hi0 = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (spk_out[1] !== prev) begin
        tog.push_back(k);
        prev = spk_out[1];
      end
      if (spk_out[0]) hi0++;
    end
    while (tog.size() < 3) tog.push_back(-1);
    check("freq_toggle0", tog[0], 4);
    check("freq_toggle1", tog[1], 16);
    check("freq_toggle2", tog[2], 28);
    check("freq_ch0_quiet", hi0, 0);
    rd(A_PERL, 8'h03, "freq_perl");
    rd(A_PERH, 8'h00, "freq_perh");
    rd(A_CHSEL, 8'h01, "freq_chsel");

    // Staged high byte is invisible until the PERL commit
    wr(A_PERH, 8'h01);
    rd(A_PERL, 8'h03, "stage_perl_old");
    rd(A_PERH, 8'h00, "stage_perh_old");
    wr(A_PERL, 8'h00);
    rd(A_PERL, 8'h00, "stage_perl_new");
    rd(A_PERH, 8'h01, "stage_perh_new");

    // Out-of-range channel select
    wr(A_CHSEL, 8'h05);
    rd(A_CHSEL, 8'h05, "inv_chsel");
    wr(A_PERL, 8'hFF);
    rd(A_PERL, 8'h00, "inv_perl");
    rd(A_PERH, 8'h00, "inv_perh");
    rd(A_DUR, 8'h00, "inv_dur");
    wr(A_CHSEL, 8'h01);
    rd(A_PERL, 8'h00, "inv_ch1_perl");
    rd(A_PERH, 8'h01, "inv_ch1_perh");
    wr(A_CHSEL, 8'h00);
    rd(A_PERL, 8'h00, "inv_ch0_perl");

    // Zero period with enable set stays silent
    wr(A_ENA, 8'h01);
    hi0 = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (spk_out[0]) hi0++;
    end
    check("per0_quiet", hi0, 0);

    // Duration 2 with DUR_DIV 2, prescale 4: stops exactly 16 clk after GEN
    wr(A_CTRL, 8'h02);
    wr(A_PERH, 8'h00);
    wr(A_PERL, 8'h01);
    wr(A_DUR, 8'h02);
    rd(A_DUR, 8'h02, "dur_set");
    wr(A_ENA, 8'h01);
    wr(A_CTRL, 8'h01);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      check($sformatf("dur_spk0_k%0d", k), int'(spk_out[0]),
            ((k >= 4 && k < 8) || (k >= 12 && k < 16)) ? 1 : 0);
      check($sformatf("dur_done_k%0d", k), int'(done_pulse), (k == 16) ? 1 : 0);
    end
    check("dur_done_count", done_cnt, 1);
    rd(A_ENA, 8'h00, "dur_ena_after");
    rd(A_DUR, 8'h00, "dur_rem_after");

    // ENA write lands on the auto-stop edge: ENA stays set and the duration reloads
    wr(A_CTRL, 8'h02);
    wr(A_DUR, 8'h02);
    wr(A_ENA, 8'h01);
    wr(A_CTRL, 8'h01);
    repeat (15) @(posedge clk);
    #1;
    wr(A_ENA, 8'h01);
    rd(A_ENA, 8'h01, "coll_ena");
    rd(A_DUR, 8'h02, "coll_dur");
    check("coll_no_done", done_cnt, 1);

    // CLR while both channels play
    wr(A_CTRL, 8'h02);
    wr(A_DUR, 8'h00);
    wr(A_PERL, 8'h02);
    wr(A_CHSEL, 8'h01);
    wr(A_PERH, 8'h00);
    wr(A_PERL, 8'h03);
    wr(A_ENA, 8'h03);
    wr(A_CTRL, 8'h01);
    repeat (10) @(posedge clk);
    #1;
    check("clr_both_playing", int'(spk_out), 3);
    wr(A_CTRL, 8'h03);
    check("clr_spk_low", int'(spk_out), 0);
    rd(A_ENA, 8'h00, "clr_ena");
    rd(A_CTRL, 8'h01, "clr_ctrl");

    // Asynchronous reset mid-tone
    wr(A_ENA, 8'h03);
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_spk", int'(spk_out), 3);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_spk", int'(spk_out), 0);
    check("async_rst_done", int'(done_pulse), 0);
    check("async_rst_oen", int'(io_out_en), 0);
    @(posedge clk); #1;
    rd(A_CTRL, 8'h00, "arst_ctrl");
    rd(A_ENA, 8'h00, "arst_ena");
    rd(A_CHSEL, 8'h00, "arst_chsel");
    rd(A_PERL, 8'h00, "arst_perl");
    rd(A_PERH, 8'h00, "arst_perh");
    rd(A_DUR, 8'h00, "arst_dur");
    rstn = 1'b1;

    @(posedge clk); #1;
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
